// File: rtl/tdm_demux4.sv
// tdm_demux4: four-slot TDM demultiplexer with SYNC framing (HUNT/LOCK) and registered channel outputs.
// Ports: clk, reset (async, active-high); F (W-bit TDM line), SYNC (slot-0 marker), EN (sample strobe);
//        A..D registered channels of the last complete frame; {S2,S1} slot expected at next enabled sample;
//        FRAME_VALID pulses when A..D update; SYNC_ERR pulses on a framing error; LOCKED high in LOCK.
module tdm_demux4 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] F,
   input  logic         SYNC,
   input  logic         EN,
   output logic [W-1:0] A,
   output logic [W-1:0] B,
   output logic [W-1:0] C,
   output logic [W-1:0] D,
   output logic         S1,
   output logic         S2,
   output logic         FRAME_VALID,
   output logic         SYNC_ERR,
   output logic         LOCKED
);
   typedef enum logic {HUNT, LOCK} state_t;
   state_t       state_q, state_d;
   logic [1:0]   slot_q, slot_d;
   logic [W-1:0] stage_a_q, stage_a_d, stage_b_q, stage_b_d, stage_c_q, stage_c_d;
   logic [W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
   logic         fv_q, fv_d, err_q, err_d;
   always_comb begin
      state_d   = state_q;
      slot_d    = slot_q;
      stage_a_d = stage_a_q;
      stage_b_d = stage_b_q;
      stage_c_d = stage_c_q;
      a_d       = a_q;
      b_d       = b_q;
      c_d       = c_q;
      d_d       = d_q;
      fv_d      = 1'b0;
      err_d     = 1'b0;
      if (EN) begin
         if (state_q == HUNT) begin
            if (SYNC) begin
               stage_a_d = F;
               slot_d    = 2'd1;
               state_d   = LOCK;
            end
         end else if (SYNC && slot_q != 2'd0) begin
            // early sync: restart the frame with this sample as slot 0
            err_d     = 1'b1;
            stage_a_d = F;
            slot_d    = 2'd1;
         end else if (!SYNC && slot_q == 2'd0) begin
            err_d   = 1'b1;
            slot_d  = 2'd0;
            state_d = HUNT;
         end else begin
            slot_d    = slot_q + 2'd1;
            stage_a_d = (slot_q == 2'd0) ? F : stage_a_q;
            stage_b_d = (slot_q == 2'd1) ? F : stage_b_q;
            stage_c_d = (slot_q == 2'd2) ? F : stage_c_q;
            if (slot_q == 2'd3) begin
               // slot D bypasses staging so the frame appears on the same edge
               a_d  = stage_a_q;
               b_d  = stage_b_q;
               c_d  = stage_c_q;
               d_d  = F;
               fv_d = 1'b1;
            end
         end
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= HUNT;
         slot_q    <= 2'd0;
         stage_a_q <= '0;
         stage_b_q <= '0;
         stage_c_q <= '0;
         a_q       <= '0;
         b_q       <= '0;
         c_q       <= '0;
         d_q       <= '0;
         fv_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         slot_q    <= slot_d;
         stage_a_q <= stage_a_d;
         stage_b_q <= stage_b_d;
         stage_c_q <= stage_c_d;
         a_q       <= a_d;
         b_q       <= b_d;
         c_q       <= c_d;
         d_q       <= d_d;
         fv_q      <= fv_d;
         err_q     <= err_d;
      end
   end
   assign A           = a_q;
   assign B           = b_q;
   assign C           = c_q;
   assign D           = d_q;
   assign S1          = slot_q[0];
   assign S2          = slot_q[1];
   assign FRAME_VALID = fv_q;
   assign SYNC_ERR    = err_q;
   assign LOCKED      = (state_q == LOCK);
endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: scoreboard bench for tdm_demux4 with W=4 and directed frames.
module tb_tdm_demux4;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] F = '0;
   logic       SYNC = 1'b0;
   logic       EN = 1'b0;
   logic [3:0] A, B, C, D;
   logic       S1, S2, FRAME_VALID, SYNC_ERR, LOCKED;
   int         total = 0;
   int         bad = 0;
   typedef struct {
      logic        err;
      logic [15:0] frame;
   } exp_t;
   exp_t q[$];
   tdm_demux4 #(.W(4)) dut (
      .clk(clk), .reset(reset), .F(F), .SYNC(SYNC), .EN(EN),
      .A(A), .B(B), .C(C), .D(D), .S1(S1), .S2(S2),
      .FRAME_VALID(FRAME_VALID), .SYNC_ERR(SYNC_ERR), .LOCKED(LOCKED)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask
   task automatic push(input logic err, input logic [15:0] frame);
      exp_t e;
      e.err = err;
      e.frame = frame;
      q.push_back(e);
   endtask
   // inputs applied right after a falling edge, held across the next rising edge
   task automatic drive(input logic en, input logic sync, input logic [3:0] f);
      EN = en;
      SYNC = sync;
      F = f;
      @(negedge clk);
   endtask
   task automatic gap2(input logic [1:0] slot);
      drive(1'b0, 1'b1, 4'($urandom));
      drive(1'b0, 1'b0, 4'($urandom));
      chk("gap_slot", {S2, S1}, slot);
   endtask
   always @(negedge clk) begin
      if (!reset && (FRAME_VALID || SYNC_ERR)) begin
         if (FRAME_VALID && SYNC_ERR) chk("fv_err_exclusive", 1, 0);
         else if (q.size() == 0) chk("unexpected_pulse", {FRAME_VALID, SYNC_ERR}, 0);
         else begin
            exp_t e;
            e = q.pop_front();
            chk("pulse_kind", SYNC_ERR, e.err);
            chk("frame_abcd", {A, B, C, D}, e.frame);
         end
      end
   end
   initial begin
      @(negedge clk);
      @(negedge clk);
      chk("reset_abcd", {A, B, C, D}, 0);
      chk("reset_locked", LOCKED, 0);
      chk("reset_slot", {S2, S1}, 0);
      chk("reset_pulses", {FRAME_VALID, SYNC_ERR}, 0);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 4'($urandom));
      chk("hunt_abcd", {A, B, C, D}, 0);
      chk("hunt_locked", LOCKED, 0);
      chk("hunt_slot", {S2, S1}, 0);
      drive(1'b1, 1'b1, 4'd1);
      chk("lock_slot1", {S2, S1}, 1);
      chk("lock_locked", LOCKED, 1);
      drive(1'b1, 1'b0, 4'd2);
      drive(1'b1, 1'b0, 4'd3);
      chk("basic_slot3", {S2, S1}, 3);
      push(1'b0, 16'h1234);
      drive(1'b1, 1'b0, 4'd4);
      chk("basic_locked", LOCKED, 1);
      chk("basic_slot0", {S2, S1}, 0);
      drive(1'b0, 1'b0, 4'd0);
      chk("basic_pending", q.size(), 0);
      drive(1'b1, 1'b1, 4'd1);
      gap2(2'd1);
      drive(1'b1, 1'b0, 4'd2);
      gap2(2'd2);
      drive(1'b1, 1'b0, 4'd3);
      gap2(2'd3);
      push(1'b0, 16'h1234);
      drive(1'b1, 1'b0, 4'd4);
      chk("gap_slot0", {S2, S1}, 0);
      drive(1'b0, 1'b0, 4'd0);
      chk("gap_pending", q.size(), 0);
      drive(1'b1, 1'b1, 4'd10);
      drive(1'b1, 1'b0, 4'd11);
      push(1'b1, 16'h1234);
      drive(1'b1, 1'b1, 4'd9);
      chk("early_slot1", {S2, S1}, 1);
      chk("early_locked", LOCKED, 1);
      drive(1'b1, 1'b0, 4'd5);
      drive(1'b1, 1'b0, 4'd6);
      push(1'b0, 16'h9567);
      drive(1'b1, 1'b0, 4'd7);
      push(1'b1, 16'h9567);
      drive(1'b1, 1'b0, 4'd3);
      chk("miss_locked", LOCKED, 0);
      chk("miss_slot", {S2, S1}, 0);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 4'(i + 1));
      chk("miss_hunt_locked", LOCKED, 0);
      chk("miss_abcd_held", {A, B, C, D}, 16'h9567);
      drive(1'b1, 1'b1, 4'd12);
      chk("relock", LOCKED, 1);
      drive(1'b1, 1'b0, 4'd13);
      drive(1'b1, 1'b0, 4'd14);
      push(1'b0, 16'hcdef);
      drive(1'b1, 1'b0, 4'd15);
      drive(1'b0, 1'b0, 4'd0);
      chk("miss_pending", q.size(), 0);
      drive(1'b1, 1'b1, 4'd2);
      drive(1'b1, 1'b0, 4'd3);
      chk("mid_slot2", {S2, S1}, 2);
      #2 reset = 1'b1;
      #1;
      chk("async_abcd", {A, B, C, D}, 0);
      chk("async_locked", LOCKED, 0);
      chk("async_slot", {S2, S1}, 0);
      @(negedge clk);
      reset = 1'b0;
      drive(1'b1, 1'b0, 4'd5);
      drive(1'b1, 1'b0, 4'd6);
      chk("post_reset_locked", LOCKED, 0);
      drive(1'b1, 1'b1, 4'd8);
      drive(1'b1, 1'b0, 4'd7);
      drive(1'b1, 1'b0, 4'd6);
      push(1'b0, 16'h8765);
      drive(1'b1, 1'b0, 4'd5);
      drive(1'b0, 1'b0, 4'd0);
      drive(1'b0, 1'b0, 4'd0);
      chk("final_pending", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
